// File: rtl/arb4_rr_ctrl_if.sv
// -----------------------------------------------------------------------------
// arb4_rr_ctrl_if
// Bundles the request/grant signals of the four-requester arbiter.
//
// Signals:
//   req      [3:0]  request vector, bit n = requester n
//   done            release strobe from the current grant holder
//   mode            0 = fixed priority (3>2>1>0), 1 = round robin
//   gnt      [3:0]  one-hot grant (registered in the arbiter)
//   gnt_idx  [1:0]  encoded index of the granted requester (registered)
//   busy            1 while a grant is held (registered)
//   dis             1 when req == 4'b0000 (combinational)
//   timeout         one-cycle pulse when a grant ends by hold timeout
//
// Modports:
//   master : requester side, drives req/done/mode, observes the grant
//   slave  : arbiter side, observes requests, drives the grant outputs
// -----------------------------------------------------------------------------
interface arb4_rr_ctrl_if;

    logic [3:0] req;
    logic       done;
    logic       mode;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       dis;
    logic       timeout;

    modport master (
        output req,
        output done,
        output mode,
        input  gnt,
        input  gnt_idx,
        input  busy,
        input  dis,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        input  mode,
        output gnt,
        output gnt_idx,
        output busy,
        output dis,
        output timeout
    );

endinterface : arb4_rr_ctrl_if

// File: rtl/arb4_rr_ctrl.sv
// -----------------------------------------------------------------------------
// arb4_rr_ctrl
// Four-requester arbiter for one shared downstream resource.
//
// A grant is chosen only while idle, either by fixed priority (requester 3
// highest, same order as a 4-to-2 priority encoder) or by round robin
// starting after the most recently released requester. Once granted, the
// holder keeps the resource until it strobes done, drops its request, or
// has held it for MAX_HOLD cycles. Every release is followed by at least
// one idle cycle before the next grant becomes visible.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   bus.slave  request/grant bundle (see arb4_rr_ctrl_if)
//
// Parameters:
//   MAX_HOLD   maximum consecutive cycles one grant may be held (1..15)
//   CNT_W      hold counter width, 2**CNT_W must exceed MAX_HOLD
// -----------------------------------------------------------------------------
module arb4_rr_ctrl #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    arb4_rr_ctrl_if.slave     bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // hold_cnt is 0 in the first grant cycle, so the last permitted cycle
    // of a grant window is the one where it reads MAX_HOLD-1.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           r_state;
    logic [3:0]       r_gnt;
    logic [1:0]       r_gnt_idx;
    logic             r_busy;
    logic             r_timeout;
    logic [1:0]       r_last;
    logic [CNT_W-1:0] r_hold_cnt;

    logic [1:0]       w_winner;
    logic             w_holder_req;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Highest set bit wins; an all-zero vector maps to 0 (never used,
    // since arbitration only happens when some request is present).
    function automatic logic [1:0] fixed_pick(input logic [3:0] req_v);
        logic [1:0] idx_v;
        casez (req_v)
            4'b1???: idx_v = 2'd3;
            4'b01??: idx_v = 2'd2;
            4'b001?: idx_v = 2'd1;
            4'b0001: idx_v = 2'd0;
            default: idx_v = 2'd0;
        endcase
        return idx_v;
    endfunction

    // Ascending search starting one past last_v, wrapping modulo 4. The
    // final candidate (k = 4) is last_v itself, so the previous holder is
    // only chosen again when nobody else is requesting.
    function automatic logic [1:0] rr_pick(input logic [3:0] req_v,
                                           input logic [1:0] last_v);
        logic [1:0] cand_v;
        logic [1:0] pick_v;
        logic       found_v;
        pick_v  = last_v;
        found_v = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand_v = last_v + 2'(k);
            if (!found_v && req_v[cand_v]) begin
                pick_v  = cand_v;
                found_v = 1'b1;
            end else begin
                found_v = found_v;
            end
        end
        return pick_v;
    endfunction

    // Encoded index to one-hot grant vector.
    function automatic logic [3:0] onehot4(input logic [1:0] idx_v);
        logic [3:0] oh_v;
        case (idx_v)
            2'd0:    oh_v = 4'b0001;
            2'd1:    oh_v = 4'b0010;
            2'd2:    oh_v = 4'b0100;
            2'd3:    oh_v = 4'b1000;
            default: oh_v = 4'b0000;
        endcase
        return oh_v;
    endfunction

    // ------------------------------------------------------------------
    // Combinational selection
    // ------------------------------------------------------------------

    // Candidate winner for the next idle-state arbitration.
    always_comb begin
        w_winner = 2'b00;
        if (bus.mode == 1'b1) begin
            w_winner = rr_pick(bus.req, r_last);
        end else begin
            w_winner = fixed_pick(bus.req);
        end
    end

    // Whether the current holder is still requesting.
    always_comb begin
        w_holder_req = 1'b0;
        if (bus.req[r_gnt_idx] == 1'b1) begin
            w_holder_req = 1'b1;
        end else begin
            w_holder_req = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Grant sequencing FSM
    // ------------------------------------------------------------------

    // State, grant outputs, hold counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 4'b0000;
            r_gnt_idx  <= 2'b00;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_hold_cnt <= '0;
            r_last     <= 2'b11;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timeout <= 1'b0;
                    if (bus.req != 4'b0000) begin
                        r_state    <= ST_GRANT;
                        r_gnt      <= onehot4(w_winner);
                        r_gnt_idx  <= w_winner;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= '0;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_gnt      <= 4'b0000;
                        r_busy     <= 1'b0;
                    end
                end

                ST_GRANT: begin
                    // done outranks the timeout check, so a done on the
                    // final permitted cycle never produces a timeout pulse.
                    if (bus.done == 1'b1) begin
                        r_state    <= ST_IDLE;
                        r_gnt      <= 4'b0000;
                        r_busy     <= 1'b0;
                        r_last     <= r_gnt_idx;
                        r_hold_cnt <= '0;
                        r_timeout  <= 1'b0;
                    end else if (w_holder_req == 1'b0) begin
                        r_state    <= ST_IDLE;
                        r_gnt      <= 4'b0000;
                        r_busy     <= 1'b0;
                        r_last     <= r_gnt_idx;
                        r_hold_cnt <= '0;
                        r_timeout  <= 1'b0;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state    <= ST_IDLE;
                        r_gnt      <= 4'b0000;
                        r_busy     <= 1'b0;
                        r_last     <= r_gnt_idx;
                        r_hold_cnt <= '0;
                        r_timeout  <= 1'b1;
                    end else begin
                        r_state    <= ST_GRANT;
                        r_hold_cnt <= r_hold_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        r_timeout  <= 1'b0;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a safe idle.
                    r_state    <= ST_IDLE;
                    r_gnt      <= 4'b0000;
                    r_busy     <= 1'b0;
                    r_hold_cnt <= '0;
                    r_timeout  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.gnt     = r_gnt;
    assign bus.gnt_idx = r_gnt_idx;
    assign bus.busy    = r_busy;
    assign bus.timeout = r_timeout;
    // Encoder "disabled" flag, independent of arbitration state.
    assign bus.dis     = (bus.req == 4'b0000);

endmodule : arb4_rr_ctrl

// File: tb/tb_arb4_rr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_arb4_rr_ctrl
// Directed bench for arb4_rr_ctrl. A behavioural model tracks who holds the
// resource and for how many cycles, and is compared to the DUT every cycle;
// directed steps additionally pin hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_arb4_rr_ctrl;

    localparam int MAX_HOLD = 15;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    arb4_rr_ctrl_if u_if ();

    arb4_rr_ctrl #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------
    // Shared check helper
    // ---------------------------------------------------------------
    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Behavioural model: holder = -1 when nobody holds the resource,
    // held = number of cycles the current grant has been visible.
    // ---------------------------------------------------------------
    int m_holder = -1;
    int m_held   = 0;
    int m_last   = 3;
    int m_idx    = 0;
    bit m_tout   = 1'b0;
    bit m_valid  = 1'b0;

    function automatic int pick(input logic [3:0] r, input logic m, input int last);
        if (m == 1'b0) begin
            for (int n = 3; n >= 0; n--) begin
                if (r[n]) return n;
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                if (r[(last + k) % 4]) return (last + k) % 4;
            end
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model_p
        int h, held, last, idx;
        bit tout;
        h = m_holder; held = m_held; last = m_last; idx = m_idx; tout = 1'b0;
        if (rst) begin
            h = -1; held = 0; last = 3; idx = 0;
        end else if (h < 0) begin
            if (u_if.req != 4'b0000) begin
                h = pick(u_if.req, u_if.mode, last);
                idx = h;
                held = 1;
            end
        end else if (u_if.done) begin
            last = h; h = -1;
        end else if (!u_if.req[h]) begin
            last = h; h = -1;
        end else if (held == MAX_HOLD) begin
            last = h; h = -1; tout = 1'b1;
        end else begin
            held = held + 1;
        end
        m_holder <= h;
        m_held   <= held;
        m_last   <= last;
        m_idx    <= idx;
        m_tout   <= tout;
        m_valid  <= m_valid | rst;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin : cmp_p
        logic [3:0] eg;
        if (m_valid) begin
            eg = 4'b0000;
            if (m_holder >= 0) eg[m_holder] = 1'b1;
            chk("m_gnt",     u_if.gnt,     eg);
            chk("m_busy",    u_if.busy,    (m_holder >= 0));
            chk("m_gnt_idx", u_if.gnt_idx, m_idx[1:0]);
            chk("m_timeout", u_if.timeout, m_tout);
            chk("m_dis",     u_if.dis,     (u_if.req == 4'b0000));
            chk("inv_onehot", $onehot0(u_if.gnt), 1'b1);
            chk("inv_busy",  u_if.busy, |u_if.gnt);
            if (u_if.busy) chk("inv_idx", u_if.gnt[u_if.gnt_idx], 1'b1);
        end
    end

    // Advance one clock; inputs change and literal checks happen 1 after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------
    // Directed stimulus with hand-computed literals
    // ---------------------------------------------------------------
    initial begin
        int rr_exp [5] = '{0, 1, 2, 3, 0};
        int cnt;
        bit released;
        logic [3:0] oh;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        u_if.req  = 4'b1010;
        u_if.done = 1'b0;
        u_if.mode = 1'b0;

        // Reset and idle
        tick(); tick();
        chk("rst_gnt",  u_if.gnt, 4'b0000);
        chk("rst_busy", u_if.busy, 1'b0);
        chk("rst_idx",  u_if.gnt_idx, 2'd0);
        chk("rst_tout", u_if.timeout, 1'b0);
        chk("rst_dis",  u_if.dis, 1'b0);
        rst = 1'b0;
        tick();
        chk("first_gnt", u_if.gnt, 4'b1000);
        chk("first_idx", u_if.gnt_idx, 2'd3);
        u_if.req = 4'b0000;
        #1;
        chk("dis_zero", u_if.dis, 1'b1);
        tick();
        chk("drop_rel", u_if.gnt, 4'b0000);
        tick();

        // Fixed priority
        u_if.mode = 1'b0;
        u_if.req  = 4'b0110;
        tick();
        chk("fix_gnt", u_if.gnt, 4'b0100);
        chk("fix_idx", u_if.gnt_idx, 2'd2);
        u_if.done = 1'b1;
        tick();
        u_if.done = 1'b0;
        chk("fix_rel", u_if.gnt, 4'b0000);
        chk("fix_idx_keep", u_if.gnt_idx, 2'd2);
        tick();
        chk("fix_regnt", u_if.gnt, 4'b0100);
        u_if.req = 4'b0001;
        tick();
        chk("fix_rel2", u_if.gnt, 4'b0000);
        tick();
        chk("fix_low_idx", u_if.gnt_idx, 2'd0);
        chk("fix_low_gnt", u_if.gnt, 4'b0001);
        u_if.req = 4'b0000;
        tick(); tick();

        // Round robin from reset (last = 3)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        u_if.mode = 1'b1;
        u_if.req  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            oh = 4'b0000;
            oh[rr_exp[i]] = 1'b1;
            chk("rr_gnt", u_if.gnt, oh);
            u_if.done = 1'b1;
            tick();
            u_if.done = 1'b0;
            chk("rr_gap", u_if.gnt, 4'b0000);
        end
        u_if.req = 4'b0000;
        tick();

        // Hold timeout
        u_if.mode = 1'b0;
        u_if.req  = 4'b0100;
        tick();
        cnt = (u_if.gnt == 4'b0100) ? 1 : 0;
        released = 1'b0;
        for (int i = 0; i < 40 && !released; i++) begin
            tick();
            if (u_if.gnt == 4'b0100) cnt++;
            else released = 1'b1;
        end
        chk("to_released", released, 1'b1);
        chk("to_window", 8'(cnt), 8'd15);
        chk("to_pulse", u_if.timeout, 1'b1);
        tick();
        chk("to_regnt", u_if.gnt, 4'b0100);
        chk("to_pulse_end", u_if.timeout, 1'b0);
        u_if.req = 4'b0000;
        tick(); tick();

        // Request drop and no preemption
        u_if.req = 4'b0010;
        tick();
        chk("np_gnt", u_if.gnt, 4'b0010);
        u_if.req = 4'b1010;
        tick();
        chk("np_hold1", u_if.gnt, 4'b0010);
        tick();
        chk("np_hold2", u_if.gnt, 4'b0010);
        u_if.req = 4'b1000;
        tick();
        chk("np_rel", u_if.gnt, 4'b0000);
        tick();
        chk("np_next", u_if.gnt, 4'b1000);
        u_if.req = 4'b0000;
        tick(); tick();

        // done on the final permitted cycle: done release, no timeout
        u_if.req = 4'b0001;
        tick();
        for (int i = 0; i < 14; i++) tick();
        chk("sim_still", u_if.gnt, 4'b0001);
        u_if.done = 1'b1;
        tick();
        u_if.done = 1'b0;
        chk("sim_rel", u_if.gnt, 4'b0000);
        chk("sim_notout", u_if.timeout, 1'b0);
        u_if.req = 4'b0000;
        tick();

        // Reset mid-grant restores last = 3
        u_if.mode = 1'b1;
        u_if.req  = 4'b1111;
        tick();
        chk("mid_gnt", u_if.gnt, 4'b0010);
        rst = 1'b1;
        tick();
        chk("mid_rst_gnt", u_if.gnt, 4'b0000);
        chk("mid_rst_tout", u_if.timeout, 1'b0);
        rst = 1'b0;
        tick();
        chk("mid_rr0", u_if.gnt, 4'b0001);
        u_if.req = 4'b0000;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_arb4_rr_ctrl

// File: doc/arb4_rr_ctrl.md
Name: arb4_rr_ctrl

Overview:
Four-requester arbiter that shares one downstream resource. It wraps the 4-to-2 priority-encoding function with grant sequencing and supports two modes. Fixed mode uses the encoder order, where request 3 is highest. Round-robin mode rotates priority after each grant. Grants are held until release, until the requester drops its request, or until a hold timeout; this bounds resource occupancy.

Parameters:
MAX_HOLD, 15, maximum consecutive cycles a single grant may be held (legal range 1..15)
CNT_W, 4, width of the hold counter (must satisfy 2^CNT_W > MAX_HOLD)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req  input  4  request vector, bit n = requester n
done  input  1  release strobe from the current grant holder
mode  input  1  0 = fixed priority (3>2>1>0), 1 = round robin
gnt  output  4  one-hot grant, registered
gnt_idx  output  2  encoded index of granted requester, registered
busy  output  1  1 while a grant is held, registered
dis  output  1  combinational, 1 when req == 4'b0000 (encoder "disabled" flag)
timeout  output  1  one-cycle pulse, registered, when a grant is released by hold timeout

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, on ports clk and rst.
- Reset values:
  - state=IDLE, gnt=4'b0000, gnt_idx=2'b00, busy=0, timeout=0, hold_cnt=0.
  - last=2'b11, so the first round-robin search starts at requester 0.
- Reset mid-grant: the same values load on the next edge and the grant drops immediately; no timeout pulse.
- States: IDLE, GRANT.
- IDLE:
  - gnt=0 and busy=0.
  - If req!=0 at edge N, the winner is registered: gnt=onehot(w), gnt_idx=w, busy=1, hold_cnt=0, state=GRANT. gnt is visible in cycle N+1, so latency is 1 cycle.
  - If req==0, stay in IDLE.
- Winner selection (evaluated only in IDLE, with mode sampled at the same edge):
  - mode=0: highest set bit of req, identical to a 4-to-2 priority encoder.
  - mode=1: first set bit searching ascending from (last+1) mod 4 with wrap, e.g. last=1 searches 2,3,0,1.
- GRANT: each edge evaluates the release conditions in this priority order:
  - rst (see above).
  - done=1 → release.
  - req[gnt_idx]=0 → release.
  - hold_cnt==MAX_HOLD-1 → release and pulse timeout=1 for one cycle.
  - Otherwise hold_cnt increments and the grant stays.
- Release:
  - state=IDLE, gnt=0, busy=0, last=gnt_idx. gnt_idx keeps its value until the next grant.
  - The following cycle is a mandatory 1-cycle gap with no grant; re-arbitration happens at the IDLE edge after it.
  - Back-to-back grants are therefore spaced by at least one idle cycle.
- Releases in fixed mode also update last, but last is used only in mode=1.
- Simultaneous done and timeout on the same edge: treat as a done release, with no timeout pulse.
- A mode change while in GRANT has no effect until the next IDLE arbitration.
- Changes to other req bits while in GRANT are ignored; there is no preemption.
- A requester holding longer than MAX_HOLD cycles is cut off; its grant window is exactly MAX_HOLD cycles of gnt high.
- dis is purely combinational on req and independent of state.
- Invariants:
  - gnt is always zero or one-hot.
  - busy == |gnt.
  - When busy=1, gnt[gnt_idx]==1.

Test Plan:
- Reset and idle: assert rst for 2 cycles with req=4'b1010, then deassert. Required during rst: gnt=0, busy=0, gnt_idx=0. Required 1 cycle after rst falls: gnt=4'b1000, gnt_idx=3. dis=0 throughout; with req=0, dis=1.
- Fixed priority: mode=0, apply req=4'b0110 → gnt=4'b0100, gnt_idx=2. Pulse done → gnt=0 next cycle, then gnt=4'b0100 again after the gap cycle. Apply req=4'b0001 alone → gnt_idx=0.
- Round-robin fairness: mode=1, req=4'b1111 constant, done pulsed in every GRANT cycle. Required grant sequence: 0,1,2,3,0, each grant separated by one idle cycle.
- Timeout: MAX_HOLD=15, req=4'b0100 held, done=0. Required: gnt high exactly 15 cycles, timeout=1 in the cycle after the 15th, then re-grant to requester 2 after the gap.
- Request drop and no-preempt: requester 1 granted. Raise req[3] → grant stays at 1. Drop req[1] → gnt=0 next cycle, then gnt=4'b1000.
- Simultaneous events: done=1 on the same edge hold_cnt reaches 14 → release with timeout=0. Separately, rst=1 mid-grant → gnt=0 next cycle and last returns to 3, so the next mode=1 grant with req=4'b1111 goes to 0.
